// File: rtl/console_tx_ctrl.sv
// console_tx_ctrl
//   Console output scheduler. The CPU-side byte strobe fills a small FIFO.
//   Each queued byte is sent as an 8N1 UART frame: one start bit (0),
//   eight data bits LSB first, and one stop bit (1). Every bit lasts
//   CLK_DIV clocks. Occupancy, busy and a saturating drop counter let
//   firmware tell when console output has fully drained.
//
// Parameters
//   CLK_DIV   clock cycles per UART bit (2..65535)
//   FIFO_AW   FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk          system clock, all logic on posedge
//   resetn       asynchronous active-low reset
//   out_byte     byte to transmit
//   out_byte_en  single-cycle write strobe for out_byte
//   full         FIFO holds 2**FIFO_AW entries
//   level        current FIFO occupancy (0..2**FIFO_AW)
//   busy         FIFO non-empty or frame in progress
//   drop_cnt     bytes discarded while full, saturates at 255
//   tx           UART serial output, idle high, registered
module console_tx_ctrl #(
    parameter int unsigned CLK_DIV = 104,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       out_byte,
    input  logic             out_byte_en,
    output logic             full,
    output logic [FIFO_AW:0] level,
    output logic             busy,
    output logic [7:0]       drop_cnt,
    output logic             tx
);

    localparam int unsigned       DEPTH     = 1 << FIFO_AW;
    localparam logic [15:0]       BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0]  LVL_FULL  = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]  LVL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = (FIFO_AW)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // FIFO storage and bookkeeping
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level_q;
    logic [7:0]         drop_q;

    // Serializer
    logic [15:0] baud, baud_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        tx_q, tx_nxt;

    logic bit_end;
    logic push;
    logic pop;
    logic drop;
    logic not_empty;

    // full comes from the registered level, so a push while full is
    // dropped even if a pop frees a slot on the same edge.
    assign full      = (level_q == LVL_FULL);
    assign not_empty = (level_q != '0);
    assign push      = out_byte_en & ~full;
    assign drop      = out_byte_en & full;
    assign bit_end   = (baud == BAUD_LAST);

    // ------------------------------------------------------------------
    // FSM state register and serializer datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            tx_q    <= tx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, pop decision and next tx value
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pop         = 1'b0;
        tx_nxt      = 1'b1;

        // Baud counter free-runs through every non-idle bit and restarts
        // at each bit boundary, so state changes line up with it.
        if (state != IDLE) begin
            baud_nxt = bit_end ? '0 : baud + 16'd1;
        end

        case (state)
            IDLE: begin
                if (not_empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    baud_nxt  = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                // Chain straight into the next frame so back-to-back
                // bytes leave no idle gap on the line.
                if (bit_end) begin
                    if (not_empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // tx is registered: derive it from where the FSM is going so the
        // line level changes on the same edge as the state.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Storage needs no reset; only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= out_byte;
        end
    end

    assign level    = level_q;
    assign drop_cnt = drop_q;
    assign busy     = (state != IDLE) | not_empty;
    assign tx       = tx_q;

endmodule

// File: tb/tb_console_tx_ctrl.sv
`timescale 1ns/1ps
module tb_console_tx_ctrl;

    localparam int D     = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * D;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [7:0]    out_byte = 8'h00;
    logic          out_byte_en = 1'b0;
    logic          full;
    logic [AW:0]   level;
    logic          busy;
    logic [7:0]    drop_cnt;
    logic          tx;

    console_tx_ctrl #(.CLK_DIV(D), .FIFO_AW(AW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .out_byte    (out_byte),
        .out_byte_en (out_byte_en),
        .full        (full),
        .level       (level),
        .busy        (busy),
        .drop_cnt    (drop_cnt),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a byte queue plus "which byte is on the wire and
    // how many cycles into its frame are we".
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    bit         m_act = 0;
    int         m_fc = 0;
    logic [7:0] m_cur = 8'h00;
    int         m_drop = 0;
    longint     cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_act  = 0;
        m_fc   = 0;
        m_drop = 0;
    endtask

    task automatic model_step();
        int sz;
        bit pre_full;
        sz = mq.size();
        pre_full = (sz == DEPTH);
        if (m_act) begin
            if (m_fc == FRAME - 1) m_act = 0;
            else m_fc++;
        end
        if (!m_act && sz != 0) begin
            m_cur = mq.pop_front();
            m_act = 1;
            m_fc  = 0;
            exp_q.push_back(m_cur);
        end
        if (out_byte_en) begin
            if (!pre_full) mq.push_back(out_byte);
            else if (m_drop < 255) m_drop++;
        end
    endtask

    function automatic logic m_tx();
        int b;
        if (!m_act) return 1'b1;
        b = m_fc / D;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!resetn) model_reset();
        else model_step();
    end

    // Per-cycle output compare against the model
    initial forever begin
        @(negedge clk);
        chk("tx", tx, m_tx());
        chk("level", level, mq.size());
        chk("full", full, (mq.size() == DEPTH) ? 1 : 0);
        chk("busy", busy, (m_act || mq.size() != 0) ? 1 : 0);
        chk("drop_cnt", drop_cnt, m_drop);
    end

    // UART receiver sampling at bit centres
    initial begin
        bit         act;
        int         cnt;
        int         j;
        logic [7:0] sh;
        act = 0;
        cnt = 0;
        sh  = 8'h00;
        forever begin
            @(negedge clk);
            if (!resetn) act = 0;
            else if (!act) begin
                if (tx == 1'b0) begin
                    act = 1;
                    cnt = 0;
                end
            end else cnt++;
            if (act && resetn && (cnt % D) == D / 2) begin
                j = cnt / D;
                if (j == 0) chk("rx_start", tx, 0);
                else if (j < 9) sh[j-1] = tx;
                else begin
                    chk("rx_stop", tx, 1);
                    rx_log.push_back(sh);
                    chk("rx_frame_expected", (exp_q.size() != 0) ? 1 : 0, 1);
                    if (exp_q.size() != 0) chk("rx_byte", sh, exp_q.pop_front());
                    act = 0;
                end
            end
        end
    end

    task automatic push1(input logic [7:0] b);
        out_byte    = b;
        out_byte_en = 1'b1;
        @(negedge clk);
        out_byte_en = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", busy, 0);
        repeat (D) @(negedge clk);
    endtask

    task automatic wait_frame_pos(input int pos, input int maxc);
        int n;
        n = 0;
        while (!(m_act && m_fc == pos) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("frame_pos_timeout", (m_act && m_fc == pos) ? 1 : 0, 1);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f41;
        string      s;
        longint     t0;
        int         n;
        int         p;

        #1 resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        #1 resetn = 1'b1;
        @(negedge clk);

        // Single byte 0x41: frame bits and busy timing
        rx_log.delete();
        f41 = 10'b1010000010;
        push1(8'h41);
        @(negedge clk);
        chk("f41_busy_start", busy, 1);
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 2 : D) @(negedge clk);
            chk("f41_bit", tx, f41[i]);
        end
        @(negedge clk);
        chk("f41_busy_last", busy, 1);
        @(negedge clk);
        chk("f41_busy_end", busy, 0);
        chk("f41_rx_count", rx_log.size(), 1);
        chk("f41_rx_byte", (rx_log.size() > 0) ? rx_log[0] : 8'hFF, 8'h41);
        repeat (3) @(negedge clk);

        // 18-byte burst: fills FIFO, last byte dropped
        rx_log.delete();
        for (int i = 0; i < 18; i++) begin
            out_byte    = 8'(i);
            out_byte_en = 1'b1;
            @(negedge clk);
        end
        out_byte_en = 1'b0;
        chk("burst_level", level, 16);
        chk("burst_full", full, 1);
        chk("burst_drop", drop_cnt, 1);

        // Push while full exactly on the STOP->START pop edge
        wait_frame_pos(FRAME - 1, 200);
        push1(8'hAA);
        chk("popedge_level", level, 15);
        chk("popedge_full", full, 0);
        chk("popedge_drop", drop_cnt, 2);

        // Hold the strobe for 300 cycles: drop counter saturates
        for (int i = 0; i < 300; i++) begin
            out_byte    = 8'($urandom);
            out_byte_en = 1'b1;
            @(negedge clk);
        end
        out_byte_en = 1'b0;
        chk("sat_drop", drop_cnt, 255);
        wait_idle(3000);
        chk("burst_rx_count_min", (rx_log.size() >= 17) ? 1 : 0, 1);
        chk("burst_rx_first", (rx_log.size() >= 17) ? rx_log[0] : 8'hFF, 8'h00);
        chk("burst_rx_17th", (rx_log.size() >= 17) ? rx_log[16] : 8'hFF, 8'h10);

        // Reset halfway through DATA bit 3, with bytes still queued
        push1(8'h5A);
        push1(8'h01);
        push1(8'h02);
        wait_frame_pos(4 * D + D / 2, 200);
        #1 resetn = 1'b0;
        model_reset();
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_level", level, 0);
        chk("abort_busy", busy, 0);
        chk("abort_drop", drop_cnt, 0);
        @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        rx_log.delete();
        push1(8'h55);
        wait_idle(500);
        chk("post_abort_count", rx_log.size(), 1);
        chk("post_abort_byte", (rx_log.size() > 0) ? rx_log[0] : 8'hFF, 8'h55);

        // "Hello\n" stream and drain time
        s = "Hello\n";
        rx_log.delete();
        t0 = cyc + 1;
        for (int i = 0; i < s.len(); i++) begin
            out_byte    = s[i];
            out_byte_en = 1'b1;
            @(negedge clk);
        end
        out_byte_en = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("hello_time", cyc - t0, 6 * FRAME + 1);
        repeat (D) @(negedge clk);
        chk("hello_len", rx_log.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("hello_char", (rx_log.size() > i) ? rx_log[i] : 8'hFF, s[i]);

        // Random traffic at several densities
        for (int ph = 0; ph < 3; ph++) begin
            p = (ph == 0) ? 5 : ((ph == 1) ? 25 : 75);
            for (int i = 0; i < 600; i++) begin
                out_byte    = 8'($urandom);
                out_byte_en = ($urandom_range(0, 99) < p) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
            out_byte_en = 1'b0;
            wait_idle(2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/console_tx_ctrl.md
Name: console_tx_ctrl

Overview:
Output-byte scheduler between the SoC's CPU-side `out_byte`/`out_byte_en` strobe and a physical UART TX pin. It buffers bytes in a small FIFO and serializes each byte as an 8N1 frame using a programmable bit-period divider. It also exposes occupancy, busy and drop status so firmware or the bench can tell when console output has fully drained before `trap`/finish.

Parameters:
CLK_DIV, 104, clock cycles per UART bit (legal range 2..65535)
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries

Ports:
clk  input  1  system clock, all logic on posedge
resetn  input  1  asynchronous active-low reset
out_byte  input  8  byte to transmit
out_byte_en  input  1  single-cycle write strobe for out_byte
full  output  1  FIFO holds 2**FIFO_AW entries
level  output  FIFO_AW+1  current FIFO occupancy
busy  output  1  FIFO non-empty or frame in progress
drop_cnt  output  8  count of bytes discarded while full, saturating
tx  output  1  UART serial output, idle high

Behaviour:
- Reset (async assert, sync release on clk): tx=1, full=0, level=0, busy=0, drop_cnt=0. FSM=IDLE, FIFO pointers=0, bit counters=0. Assertion mid-frame aborts the frame immediately; no partial stop bit.
- Push rule: on a clk edge with out_byte_en=1 and full=0, out_byte is written at the write pointer and the pointer increments modulo depth.
  - full is evaluated from the pre-edge level. A push while full is dropped even if a pop happens in the same cycle.
  - On a dropped push, drop_cnt increments, saturating at 255.
- Pop rule: in IDLE with level!=0, on the next edge the head byte is loaded into the shift register, the read pointer increments, and the FSM enters START.
- Level update:
  - Push-only: level+1.
  - Pop-only: level-1.
  - Push and pop in the same cycle: level unchanged.
  - full = (level == 2**FIFO_AW).
- FSM states IDLE, START, DATA, STOP. A baud counter runs 0..CLK_DIV-1 in every non-IDLE state; a state's bit ends when the counter reaches CLK_DIV-1.
  - IDLE: tx=1. Go to START on pop.
  - START: tx=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Shift right at the end of each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then go to START directly if level!=0 (popping on that same edge), otherwise IDLE. There is no extra idle cycle between back-to-back frames.
- tx is a registered output; it changes only on clk edges, or on async reset.
- Latency: a byte pushed into an empty, idle block at edge N is popped at edge N+1, and tx falls after edge N+1.
- Frame length is exactly 10*CLK_DIV cycles.
- busy = (state != IDLE) | (level != 0), registered-equivalent (no combinational path from out_byte_en).
- Pointer wrap-around is handled by the extra level bit; no entry is lost or duplicated across wrap.

Test Plan:
- CLK_DIV=4, FIFO_AW=4; push 0x41 once -> tx samples at the middle of each 4-cycle bit read 0,1,0,0,0,0,0,1,0,1. The frame spans 40 cycles from edge N+1. busy drops on the edge that ends STOP.
- Push 18 bytes 0x00..0x11 on consecutive cycles from idle -> 0x00 popped at cycle 1; 0x01..0x10 buffered (level peaks at 16, full=1); 0x11 dropped, drop_cnt=1. The 17 accepted bytes appear on tx in order, with frames contiguous (no idle gap).
- Hold out_byte_en=1 for 300 cycles while full -> drop_cnt saturates at 255 and does not wrap to 0.
- While full and exactly on a pop edge (STOP->START), push 0xAA -> 0xAA dropped, level goes 16->15, drop_cnt increments.
- Assert resetn=0 for 1 cycle halfway through DATA bit 3 -> tx=1 within the same cycle (async). level=0, busy=0, drop_cnt=0. After release, a new push of 0x55 transmits a clean frame.
- Stream "Hello\n" through the block, with a bench UART receiver sampling at bit centres -> decoded string equals "Hello\n". Total time from the first push to busy=0 is 6*10*CLK_DIV+1 cycles.
